// File: rtl/tr_pkg.sv
// rtl/tr_pkg.sv - shared constants and encodings for the step/dir monitor
// Contents: default period width, direction encoding, limit_hit bit positions,
//           post-reset rise blanking length.
package tr_pkg;

    localparam int PER_W_DEF = 12;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    localparam int LIM_UP_BIT = 1;
    localparam int LIM_DN_BIT = 0;

    // Clocks after reset release during which no rise may be reported, so a
    // step line that was already high while in reset does not count as a step.
    localparam int BLANK_CLKS = 3;

endpackage

// File: rtl/step_dir_monitor_if.sv
// rtl/step_dir_monitor_if.sv - step/dir driver-side signal bundle
// master: drives drv_enable_SM, drv_step, drv_dir, clr_pos, err_clr; observes results
// slave : monitor side, reports position, step_period, period_valid, moving,
//         dir_err, overspeed, limit_hit[1:0]
interface step_dir_monitor_if #(
    parameter int POS_W = 16,
    parameter int PER_W = 12
);
    logic             drv_enable_SM;
    logic             drv_step;
    logic             drv_dir;
    logic             clr_pos;
    logic             err_clr;
    logic [POS_W-1:0] position;
    logic [PER_W-1:0] step_period;
    logic             period_valid;
    logic             moving;
    logic             dir_err;
    logic             overspeed;
    logic [1:0]       limit_hit;

    modport master (
        output drv_enable_SM, drv_step, drv_dir, clr_pos, err_clr,
        input  position, step_period, period_valid, moving, dir_err, overspeed, limit_hit
    );

    modport slave (
        input  drv_enable_SM, drv_step, drv_dir, clr_pos, err_clr,
        output position, step_period, period_valid, moving, dir_err, overspeed, limit_hit
    );

endinterface

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - 2-FF synchroniser with registered rising-edge detect
// Ports: clk, rst (sync, active-low), din (asynchronous input),
//        sync (synchronised level), rise (1-clk strobe, registered)
module sync_edge
    import tr_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise
);

    localparam int                 BLANK_W    = $clog2(BLANK_CLKS + 1);
    localparam logic [BLANK_W-1:0] BLANK_INIT = BLANK_W'(BLANK_CLKS);

    logic               s1_q, s1_d;
    logic               s2_q, s2_d;
    logic               s3_q, s3_d;
    logic               rise_q, rise_d;
    logic [BLANK_W-1:0] blank_q, blank_d;

    always_comb begin
        s1_d    = din;
        s2_d    = s1_q;
        s3_d    = s2_q;
        blank_d = (blank_q != '0) ? blank_q - BLANK_W'(1) : '0;
        // A level that was high through reset shows up as a rise while the
        // pipeline refills; suppress it until the blanking count expires.
        rise_d  = s2_q & ~s3_q & (blank_q == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            rise_q  <= 1'b0;
            blank_q <= BLANK_INIT;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            rise_q  <= rise_d;
            blank_q <= blank_d;
        end
    end

    assign sync = s2_q;
    assign rise = rise_q;

endmodule

// File: rtl/step_dir_monitor.sv
// rtl/step_dir_monitor.sv - decodes drv_step/drv_dir into position, step period and fault flags
// Ports: clk, rst (sync, active-low), bus (step_dir_monitor_if.slave):
//        in  drv_enable_SM, drv_step, drv_dir, clr_pos, err_clr
//        out position, step_period, period_valid, moving, dir_err, overspeed, limit_hit
module step_dir_monitor
    import tr_pkg::*;
#(
    parameter int POS_W      = 16,
    parameter int POS_MIN    = 0,
    parameter int POS_MAX    = 1000,
    parameter int POS_HOME   = 500,
    parameter int PER_W      = PER_W_DEF,
    parameter int DIR_SETUP  = 2,
    parameter int MIN_PERIOD = 4
) (
    input logic                clk,
    input logic                rst,
    step_dir_monitor_if.slave  bus
);

    localparam logic [POS_W-1:0] POS_MIN_L    = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0] POS_MAX_L    = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] POS_HOME_L   = POS_W'(POS_HOME);
    localparam int               DC_W         = (DIR_SETUP < 1) ? 1 : $clog2(DIR_SETUP + 1);
    localparam logic [DC_W-1:0]  DIR_SETUP_L  = DC_W'(DIR_SETUP);
    localparam logic [PER_W-1:0] PER_MAX      = '1;
    localparam logic [PER_W:0]   MIN_PERIOD_L = (PER_W + 1)'(MIN_PERIOD);

    logic step_rise;
    logic step_sync_unused;
    logic dir_s;
    logic dir_rise_unused;
    logic accept;
    logic dir_chg;
    logic [PER_W:0] cnt_inc;

    logic [POS_W-1:0] position_q,     position_d;
    logic [PER_W-1:0] step_period_q,  step_period_d;
    logic             period_valid_q, period_valid_d;
    logic             moving_q,       moving_d;
    logic             dir_err_q,      dir_err_d;
    logic             overspeed_q,    overspeed_d;
    logic [1:0]       limit_hit_q,    limit_hit_d;
    logic [PER_W-1:0] cnt_q,          cnt_d;
    logic             has_prev_q,     has_prev_d;
    logic             dir_prev_q,     dir_prev_d;
    logic [DC_W-1:0]  dir_cnt_q,      dir_cnt_d;

    sync_edge u_step_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.drv_step),
        .sync (step_sync_unused),
        .rise (step_rise)
    );

    // Same depth as the step path so dir_s and the step rise see the pins
    // with matching delay; only the level is needed here.
    sync_edge u_dir_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.drv_dir),
        .sync (dir_s),
        .rise (dir_rise_unused)
    );

    assign accept  = step_rise & bus.drv_enable_SM;
    assign dir_chg = dir_s ^ dir_prev_q;
    assign cnt_inc = {1'b0, cnt_q} + (PER_W + 1)'(1);

    always_comb begin
        position_d     = position_q;
        step_period_d  = step_period_q;
        period_valid_d = 1'b0;
        moving_d       = moving_q;
        // Sticky flags: err_clr drops them, any set below overrides the clear.
        dir_err_d      = dir_err_q & ~bus.err_clr;
        overspeed_d    = overspeed_q & ~bus.err_clr;
        limit_hit_d    = limit_hit_q & ~{2{bus.err_clr}};
        cnt_d          = cnt_q;
        has_prev_d     = has_prev_q;
        dir_prev_d     = dir_s;
        dir_cnt_d      = dir_cnt_q;

        // Cycles since dir_s last changed, saturating at the setup window.
        if (dir_chg) begin
            dir_cnt_d = '0;
        end else if (dir_cnt_q < DIR_SETUP_L) begin
            dir_cnt_d = dir_cnt_q + DC_W'(1);
        end

        if (step_rise && (dir_cnt_q < DIR_SETUP_L)) begin
            dir_err_d = 1'b1;
        end

        // Position: a home load takes precedence and swallows a coincident step.
        if (bus.clr_pos) begin
            position_d = POS_HOME_L;
        end else if (accept) begin
            if (dir_s == DIR_UP) begin
                if (position_q == POS_MAX_L) begin
                    limit_hit_d[LIM_UP_BIT] = 1'b1;
                end else begin
                    position_d = position_q + POS_W'(1);
                end
            end else begin
                if (position_q == POS_MIN_L) begin
                    limit_hit_d[LIM_DN_BIT] = 1'b1;
                end else begin
                    position_d = position_q - POS_W'(1);
                end
            end
        end

        // Period measurement. The measured interval is cnt+1 because the
        // counter restarts at 0 on the edge that accepts a step.
        if (!bus.drv_enable_SM) begin
            cnt_d      = '0;
            has_prev_d = 1'b0;
            moving_d   = 1'b0;
        end else if (accept) begin
            cnt_d      = '0;
            has_prev_d = 1'b1;
            moving_d   = 1'b1;
            if (has_prev_q) begin
                step_period_d  = (cnt_q == PER_MAX) ? PER_MAX : cnt_inc[PER_W-1:0];
                period_valid_d = 1'b1;
                if (cnt_inc < MIN_PERIOD_L) begin
                    overspeed_d = 1'b1;
                end
            end
        end else if (cnt_q != PER_MAX) begin
            cnt_d = cnt_inc[PER_W-1:0];
        end else begin
            moving_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            position_q     <= POS_HOME_L;
            step_period_q  <= '0;
            period_valid_q <= 1'b0;
            moving_q       <= 1'b0;
            dir_err_q      <= 1'b0;
            overspeed_q    <= 1'b0;
            limit_hit_q    <= 2'b00;
            cnt_q          <= '0;
            has_prev_q     <= 1'b0;
            dir_prev_q     <= 1'b0;
            dir_cnt_q      <= '0;
        end else begin
            position_q     <= position_d;
            step_period_q  <= step_period_d;
            period_valid_q <= period_valid_d;
            moving_q       <= moving_d;
            dir_err_q      <= dir_err_d;
            overspeed_q    <= overspeed_d;
            limit_hit_q    <= limit_hit_d;
            cnt_q          <= cnt_d;
            has_prev_q     <= has_prev_d;
            dir_prev_q     <= dir_prev_d;
            dir_cnt_q      <= dir_cnt_d;
        end
    end

    assign bus.position     = position_q;
    assign bus.step_period  = step_period_q;
    assign bus.period_valid = period_valid_q;
    assign bus.moving       = moving_q;
    assign bus.dir_err      = dir_err_q;
    assign bus.overspeed    = overspeed_q;
    assign bus.limit_hit    = limit_hit_q;

endmodule

// File: tb/tb_step_dir_monitor.sv
// tb/tb_step_dir_monitor.sv - self-checking bench for step_dir_monitor
module tb_step_dir_monitor;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp_v;

    typedef struct {
        logic dir;
        int   n;
        int   gap;
        int   exp_pos;
        int   exp_per;
    } vec_t;

    vec_t vecs[4];

    step_dir_monitor_if #(.POS_W(16), .PER_W(12)) bus ();

    step_dir_monitor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-clk step pulses spaced gap clocks apart; every step after the
    // first has a known period and is queued for the scoreboard.
    task automatic burst(input int n, input int gap, input bit expect_valid);
        for (int i = 0; i < n; i++) begin
            if (expect_valid && i > 0) exp_q.push_back(gap);
            bus.drv_step = 1'b1;
            tick(1);
            bus.drv_step = 1'b0;
            tick(gap - 1);
        end
    endtask

    task automatic reenable(input logic dir);
        bus.drv_enable_SM = 1'b0;
        bus.drv_dir       = dir;
        tick(2);
        bus.drv_enable_SM = 1'b1;
        tick(3);
    endtask

    task automatic pulse_err_clr();
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
    endtask

    // Scoreboard: every period_valid strobe must match the oldest queued period.
    always @(negedge clk) begin
        if (bus.period_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_valid: got strobe with step_period=%0d expected none",
                         bus.step_period);
            end else begin
                exp_v = exp_q.pop_front();
                check("sb_step_period", int'(bus.step_period), exp_v);
            end
        end
    end

    initial begin
        vecs[0] = '{dir: 1'b1, n: 10, gap: 5, exp_pos: 510, exp_per: 5};
        vecs[1] = '{dir: 1'b0, n: 4,  gap: 7, exp_pos: 506, exp_per: 7};
        vecs[2] = '{dir: 1'b1, n: 3,  gap: 4, exp_pos: 509, exp_per: 4};
        vecs[3] = '{dir: 1'b0, n: 5,  gap: 6, exp_pos: 504, exp_per: 6};

        rst               = 1'b0;
        bus.drv_enable_SM = 1'b1;
        bus.drv_dir       = 1'b1;
        bus.drv_step      = 1'b1;
        bus.clr_pos       = 1'b0;
        bus.err_clr       = 1'b0;
        tick(3);

        check("rst_position", int'(bus.position), 500);
        check("rst_step_period", int'(bus.step_period), 0);
        check("rst_period_valid", int'(bus.period_valid), 0);
        check("rst_moving", int'(bus.moving), 0);
        check("rst_dir_err", int'(bus.dir_err), 0);
        check("rst_overspeed", int'(bus.overspeed), 0);
        check("rst_limit_hit", int'(bus.limit_hit), 0);

        // Step held high through reset must not count.
        rst = 1'b1;
        tick(10);
        check("blank_position", int'(bus.position), 500);
        check("blank_moving", int'(bus.moving), 0);
        bus.drv_step = 1'b0;
        tick(5);

        for (int i = 0; i < 4; i++) begin
            reenable(vecs[i].dir);
            burst(vecs[i].n, vecs[i].gap, 1'b1);
            tick(4);
            check($sformatf("v%0d_position", i), int'(bus.position), vecs[i].exp_pos);
            check($sformatf("v%0d_step_period", i), int'(bus.step_period), vecs[i].exp_per);
            check($sformatf("v%0d_moving", i), int'(bus.moving), 1);
            check($sformatf("v%0d_flags", i),
                  int'({bus.dir_err, bus.overspeed, bus.limit_hit}), 0);
            check($sformatf("v%0d_sb_drained", i), exp_q.size(), 0);
        end

        // Direction flips on the same clk as the step rise.
        reenable(1'b1);
        tick(2);
        bus.drv_dir  = 1'b0;
        bus.drv_step = 1'b1;
        tick(1);
        bus.drv_step = 1'b0;
        tick(4);
        check("dirsetup_dir_err", int'(bus.dir_err), 1);
        check("dirsetup_position", int'(bus.position), 503);
        pulse_err_clr();
        check("dirsetup_cleared", int'(bus.dir_err), 0);

        // Steps every 3 clk; err_clr coincides with the third accepted rise.
        reenable(1'b1);
        burst(2, 3, 1'b1);
        exp_q.push_back(3);
        bus.drv_step = 1'b1;
        tick(1);
        bus.drv_step = 1'b0;
        check("ovs_after_2nd", int'(bus.overspeed), 1);
        check("ovs_period", int'(bus.step_period), 3);
        tick(2);
        pulse_err_clr();
        check("ovs_set_wins_clr", int'(bus.overspeed), 1);
        tick(2);
        check("ovs_position", int'(bus.position), 506);
        pulse_err_clr();
        check("ovs_cleared", int'(bus.overspeed), 0);

        // Upper travel limit.
        bus.drv_enable_SM = 1'b0;
        bus.clr_pos       = 1'b1;
        tick(1);
        bus.clr_pos = 1'b0;
        tick(1);
        check("clr_pos_home", int'(bus.position), 500);
        reenable(1'b1);
        burst(499, 4, 1'b1);
        tick(4);
        check("lim_up_999", int'(bus.position), 999);
        check("lim_up_none_yet", int'(bus.limit_hit), 0);
        reenable(1'b1);
        burst(3, 4, 1'b1);
        tick(4);
        check("lim_up_hold", int'(bus.position), 1000);
        check("lim_up_flag", int'(bus.limit_hit), 2);
        check("lim_up_sb_drained", exp_q.size(), 0);
        pulse_err_clr();
        check("lim_clr", int'(bus.limit_hit), 0);

        // Lower travel limit.
        bus.drv_enable_SM = 1'b0;
        bus.drv_dir       = 1'b0;
        bus.clr_pos       = 1'b1;
        tick(1);
        bus.clr_pos = 1'b0;
        reenable(1'b0);
        burst(499, 4, 1'b1);
        tick(4);
        check("lim_dn_1", int'(bus.position), 1);
        reenable(1'b0);
        burst(3, 4, 1'b1);
        tick(4);
        check("lim_dn_hold", int'(bus.position), 0);
        check("lim_dn_flag", int'(bus.limit_hit), 1);

        // Disable during steps, then re-enable.
        reenable(1'b1);
        burst(1, 5, 1'b1);
        tick(4);
        check("en_pre_position", int'(bus.position), 1);
        check("en_pre_moving", int'(bus.moving), 1);
        bus.drv_enable_SM = 1'b0;
        burst(3, 4, 1'b0);
        tick(4);
        check("en_off_position", int'(bus.position), 1);
        check("en_off_moving", int'(bus.moving), 0);
        bus.drv_enable_SM = 1'b1;
        tick(3);
        burst(2, 5, 1'b1);
        tick(4);
        check("en_on_position", int'(bus.position), 3);
        check("en_on_step_period", int'(bus.step_period), 5);
        check("en_on_sb_drained", exp_q.size(), 0);

        // Long idle saturates the period counter.
        reenable(1'b1);
        burst(1, 5, 1'b1);
        tick(5000);
        check("idle_moving", int'(bus.moving), 0);
        exp_q.push_back(4095);
        bus.drv_step = 1'b1;
        tick(1);
        bus.drv_step = 1'b0;
        tick(5);
        check("idle_step_period", int'(bus.step_period), 4095);
        check("idle_position", int'(bus.position), 5);
        check("idle_moving_again", int'(bus.moving), 1);

        // clr_pos coincides with an accepted rise: home wins, period still updates.
        exp_q.push_back(6);
        bus.drv_step = 1'b1;
        tick(1);
        bus.drv_step = 1'b0;
        tick(2);
        bus.clr_pos = 1'b1;
        tick(1);
        bus.clr_pos = 1'b0;
        tick(2);
        check("clrstep_position", int'(bus.position), 500);
        check("clrstep_step_period", int'(bus.step_period), 6);
        check("clrstep_sb_drained", exp_q.size(), 0);

        // Mid-operation reset.
        reenable(1'b1);
        burst(1, 5, 1'b1);
        tick(4);
        check("midrst_pre_position", int'(bus.position), 501);
        rst = 1'b0;
        tick(1);
        check("midrst_position", int'(bus.position), 500);
        check("midrst_step_period", int'(bus.step_period), 0);
        check("midrst_moving", int'(bus.moving), 0);
        check("midrst_limit_hit", int'(bus.limit_hit), 0);
        rst = 1'b1;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
